// File: rtl/fu_pkg.sv
// fu_pkg: shared functional-unit indices and sizing for the write-back stage
package fu_pkg;
    localparam int NUM_FU   = 5;
    localparam int FU_IDX_W = 3;
    localparam logic [FU_IDX_W-1:0] FU_ALU  = 3'd0;
    localparam logic [FU_IDX_W-1:0] FU_MEM  = 3'd1;
    localparam logic [FU_IDX_W-1:0] FU_MUL  = 3'd2;
    localparam logic [FU_IDX_W-1:0] FU_DIV  = 3'd3;
    localparam logic [FU_IDX_W-1:0] FU_JUMP = 3'd4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting the search at ptr
module rr_arbiter #(
    parameter int N  = fu_pkg::NUM_FU,
    parameter int IW = fu_pkg::FU_IDX_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          grant_valid,
    output logic [IW-1:0] grant
);
    function automatic int wrap(input int a);
        return a >= N ? a - N : a;
    endfunction
    // walk the search order backwards so the requester nearest ptr wins last
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap(int'(ptr) + k)]) begin
                grant_valid = 1'b1;
                grant       = IW'(wrap(int'(ptr) + k));
            end
        end
    end
endmodule

// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter: per-FU result slots drained round-robin onto the register-file write port
module fu_wb_arbiter #(
    parameter int NUM_FU = fu_pkg::NUM_FU,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FU-1:0]            fu_finish,
    input  logic [NUM_FU-1:0]            fu_wen,
    input  logic [NUM_FU*RD_W-1:0]       fu_rd,
    input  logic [NUM_FU*DATA_W-1:0]     fu_data,
    output logic [NUM_FU-1:0]            slot_busy,
    output logic                         wb_valid,
    output logic [fu_pkg::FU_IDX_W-1:0]  wb_fu,
    output logic                         rf_we,
    output logic [RD_W-1:0]              rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic                         overflow_err
);
    import fu_pkg::*;
    logic [NUM_FU-1:0]   valid, wen, drain, load;
    logic [RD_W-1:0]     rd   [NUM_FU];
    logic [DATA_W-1:0]   data [NUM_FU];
    logic [FU_IDX_W-1:0] ptr, grant;
    logic                grant_valid;
    rr_arbiter #(.N(NUM_FU), .IW(FU_IDX_W)) u_arb (
        .req(valid),
        .ptr(ptr),
        .grant_valid(grant_valid),
        .grant(grant)
    );
    assign slot_busy = valid;
    // a slot accepts a finish when empty or when it is being drained at the same edge
    always_comb begin
        drain = grant_valid ? NUM_FU'(1) << grant : '0;
        load  = fu_finish & (~valid | drain);
    end
    // slot occupancy, sticky overflow and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid        <= '0;
            overflow_err <= 1'b0;
            ptr          <= '0;
        end else begin
            valid        <= (valid & ~drain) | load;
            overflow_err <= overflow_err | (|(fu_finish & valid & ~drain));
            if (grant_valid) ptr <= grant == FU_IDX_W'(NUM_FU - 1) ? '0 : grant + 1'b1;
        end
    end
    // slot payload only matters while valid, so it carries no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (load[i]) begin
                wen[i]  <= fu_wen[i];
                rd[i]   <= fu_rd[i*RD_W +: RD_W];
                data[i] <= fu_data[i*DATA_W +: DATA_W];
            end
        end
    end
    // registered retirement; address and data hold when nothing retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_fu    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_valid) begin
            wb_valid <= 1'b1;
            wb_fu    <= grant;
            rf_we    <= wen[grant] && rd[grant] != '0;
            rf_waddr <= rd[grant];
            rf_wdata <= data[grant];
        end else begin
            wb_valid <= 1'b0;
            rf_we    <= 1'b0;
        end
    end
endmodule
